// File: rtl/gf64_pow_seq.sv
`timescale 1ns/1ps
// Sequential GF(2^6) power map y = x^e by left-to-right square-and-multiply on one shared multiplier.
// Latency EXP_W + popcount(e) cycles; requests stall while busy, results hold until out_ready.
module gf64_pow_seq #(
    parameter int         EXP_W = 6,
    parameter logic [6:0] POLY  = 7'b1000011
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       x,
    input  logic [EXP_W-1:0] e,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       y
);
    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [5:0]       r_xr, r_acc, r_y;
    logic [EXP_W-1:0] r_er;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [5:0]       w_m, w_prod;

    // Shift-and-add multiply with the reduction folded into each shift of a.
    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p, s;
        p = '0;
        s = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ s;
            s = {s[4:0], 1'b0} ^ (s[5] ? POLY[5:0] : 6'd0);
        end
        return p;
    endfunction

    always_comb begin
        w_m         = (r_state == SQR) ? r_acc : r_xr;
        w_prod      = gf_mul(r_acc, w_m);
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            IDLE: if (in_valid) begin
                w_state_nxt = SQR;
                w_idx_nxt   = IDX_W'(EXP_W - 1);
            end
            SQR: begin
                if (r_er[r_idx])         w_state_nxt = MUL;
                else if (r_idx == '0)    w_state_nxt = DONE;
                else                     w_idx_nxt   = r_idx - 1'b1;
            end
            MUL: begin
                if (r_idx == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = SQR;
                    w_idx_nxt   = r_idx - 1'b1;
                end
            end
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_xr    <= '0;
            r_er    <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (r_state == IDLE && in_valid) begin
                r_xr  <= x;
                r_er  <= e;
                r_acc <= 6'd1;
            end
            if (r_state == SQR || r_state == MUL) begin
                r_acc <= w_prod;
                // y is captured only on the final operation so it stays put across idle periods.
                if (w_state_nxt == DONE) r_y <= w_prod;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign y         = r_y;
endmodule

// File: tb/tb_gf64_pow_seq.sv
`timescale 1ns/1ps
// Bench for gf64_pow_seq: directed and randomized jobs, scoreboard queue checked by an independent monitor
// against a repeated-multiplication reference model of x^e mod x^6+x+1.
module tb_gf64_pow_seq;
    localparam int EXP_W = 6;

    logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [5:0] in_x, in_e, y;

    gf64_pow_seq #(.EXP_W(EXP_W), .POLY(7'b1000011)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(in_x), .e(in_e), .out_valid(out_valid), .out_ready(out_ready), .y(y)
    );

    typedef struct { int y; int acc; int lat; } exp_t;
    exp_t sb[$];

    int n_checks = 0, n_fail = 0, cyc = 0, mode = 0;
    int held_y = 0;
    bit prev_v = 0;

    initial begin clk = 0; forever #5 clk = ~clk; end
    initial forever @(posedge clk) cyc++;

    // out_ready policy: 0 = tied high, 1 = random throttle, 2 = held low
    initial forever begin
        @(negedge clk);
        out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp_v, cyc);
        end
    endtask

    // Polynomial product to 11 bits, then long-division reduction by 0x43.
    function automatic int gmul(input int a, input int b);
        int p = 0;
        for (int i = 0; i < 6; i++) if (((b >> i) & 1) == 1) p = p ^ (a << i);
        for (int i = 10; i >= 6; i--) if (((p >> i) & 1) == 1) p = p ^ ('h43 << (i - 6));
        return p;
    endfunction

    function automatic int gpow(input int xv, input int ev);
        int r = 1;
        for (int i = 0; i < ev; i++) r = gmul(r, xv);
        return r;
    endfunction

    task automatic issue(input int xv, input int ev, input int yexp);
        int n = 0;
        @(negedge clk);
        in_x = 6'(xv); in_e = 6'(ev); in_valid = 1'b1;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        sb.push_back('{yexp, cyc + 1, EXP_W + $countones(6'(ev))});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 600) begin @(negedge clk); n++; end
        if (sb.size() != 0 || out_valid) chk("drain_timeout", 0, 1);
    endtask

    // Monitor: pop on each rising out_valid, check value, latency and hold stability.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_v = 0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) chk("unexpected_output", 1, 0);
                else begin
                    exp_t ex;
                    ex = sb.pop_front();
                    chk("y", int'(y), ex.y);
                    chk("latency", cyc - ex.acc, ex.lat);
                end
                held_y = int'(y);
            end else if (out_valid && prev_v) begin
                chk("y_stable", int'(y), held_y);
            end
            if (out_valid && in_ready) chk("ready_with_valid", 1, 0);
            prev_v = out_valid;
        end
    end

    int cx[5] = '{0, 0, 2, 3, 2};
    int ce[5] = '{0, 13, 6, 2, 63};
    int cy[5] = '{1, 0, 3, 5, 1};

    initial begin
        int n;
        rst_n = 0; in_valid = 0; in_x = 0; in_e = 0; out_ready = 1;
        #22;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_y", int'(y), 0);
        @(negedge clk) rst_n = 1;

        issue(2, 13, 'h0A);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (out_valid) break;
            chk("busy_in_ready", int'(in_ready), 0);
            n++;
        end
        if (!out_valid) chk("first_result_timeout", 0, 1);
        drain();

        for (int i = 0; i < 5; i++) issue(cx[i], ce[i], cy[i]);
        drain();

        // Backpressure with a stray request during the stall window.
        mode = 2;
        issue(3, 5, gpow(3, 5));
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        if (!out_valid) chk("bp_result_timeout", 0, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 1) begin in_x = 6'h07; in_e = 6'd9; in_valid = 1'b1; end
            if (c == 2) in_valid = 1'b0;
            chk("bp_y_hold", int'(y), gpow(3, 5));
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_out_valid", int'(out_valid), 1);
        end
        in_valid = 1'b0;
        mode = 0;
        issue(5, 33, gpow(5, 33));
        drain();

        // Asynchronous reset during the 4th operation cycle.
        issue(2, 13, 'h0A);
        repeat (3) @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("arst_out_valid", int'(out_valid), 0);
        chk("arst_y", int'(y), 0);
        chk("arst_in_ready", int'(in_ready), 1);
        sb.delete();
        @(negedge clk);
        @(negedge clk) rst_n = 1;
        issue(2, 13, 'h0A);
        drain();

        mode = 1;
        for (int xv = 0; xv < 64; xv++) issue(xv, 13, gpow(xv, 13));
        for (int xv = 0; xv < 64; xv++) issue(xv, 62, gpow(xv, 62));
        for (int k = 0; k < 30; k++) begin
            int xv = $urandom_range(0, 63);
            int ev = $urandom_range(0, 63);
            issue(xv, ev, gpow(xv, ev));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
